// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, and holds the word in IR behind a valid/ready handshake.
// Optional branch delay slot is enabled by defining FETCH_DELAY_SLOT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [15:0] imm16,
    input  logic [31:0] imm_ext,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic        misalign
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_misalign;
    logic        w_accept;
    logic        w_redirect;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_tgt;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_accept   = (r_state == HOLD) && instr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   if (imem_ack)    w_state_nxt = HOLD;
            HOLD:    if (instr_ready) w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            FETCH:   imem_req    = 1'b1;
            HOLD:    instr_valid = 1'b1;
            default: imem_req    = 1'b0;
        endcase
    end

    // Redirect priority: jump_reg > jump > branch_taken
    always_comb begin
        w_redirect     = 1'b1;
        w_redirect_tgt = w_pc_plus4;
        if (jump_reg)          w_redirect_tgt = {reg_target[31:2], 2'b00};
        else if (jump)         w_redirect_tgt = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
        else if (branch_taken) w_redirect_tgt = w_pc_plus4 + (imm_ext << 2);
        else                   w_redirect     = 1'b0;
    end

`ifdef FETCH_DELAY_SLOT_EN
    logic [31:0] r_pending;
    logic        r_pending_valid;

    // The slot instruction always follows sequentially; its own redirect inputs are ignored.
    assign w_next_pc = r_pending_valid ? r_pending : w_pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
        end else if (w_accept) begin
            if (r_pending_valid) begin
                r_pending_valid <= 1'b0;
            end else if (w_redirect) begin
                r_pending       <= w_redirect_tgt;
                r_pending_valid <= 1'b1;
            end
        end
    end
`else
    assign w_next_pc = w_redirect ? w_redirect_tgt : w_pc_plus4;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_accept && jump_reg && (reg_target[1:0] != 2'b00);
            if (r_state == FETCH && imem_ack) r_ir <= imem_rdata;
            if (w_accept)                     r_pc <= w_next_pc;
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign instr     = r_ir;
    assign imm16     = r_ir[15:0];
    assign misalign  = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of instructions is executed one by one, expected
// fetch addresses flow through a scoreboard queue; reset-mid-fetch is a hand-written sequence.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [15:0] imm16;
    logic [31:0] imm_ext;
    logic        branch_taken;
    logic        jump;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        misalign;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .imm16       (imm16),
        .imm_ext     (imm_ext),
        .branch_taken(branch_taken),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .reg_target  (reg_target),
        .misalign    (misalign)
    );

    typedef struct {
        logic [31:0] word;
        logic        br;
        logic        j;
        logic        jr;
        logic [31:0] imm;
        logic [31:0] rt;
        int          ack_wait;
        int          stall;
        logic [31:0] exp_next;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs[14];
    vec_t        vx;
    logic [31:0] sb[$];
    int          n_pass;
    int          n_total;
    logic [31:0] m_pend;
    logic        m_pend_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

`ifdef FETCH_DELAY_SLOT_EN
    function automatic logic [31:0] ref_target(input logic [31:0] p, input vec_t v);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (v.jr)     return {v.rt[31:2], 2'b00};
        else if (v.j) return {p4[31:28], v.word[25:0], 2'b00};
        else          return p4 + {v.imm[29:0], 2'b00};
    endfunction
`endif

    task automatic clear_ctrl();
        branch_taken = 1'b0;
        jump         = 1'b0;
        jump_reg     = 1'b0;
        imm_ext      = '0;
        reg_target   = '0;
    endtask

    // Runs one instruction from its FETCH cycle through acceptance; called at a negedge with the DUT in FETCH.
    task automatic do_instr(input vec_t v);
        logic [31:0] e;
        logic [31:0] nx;
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, e);
        chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
        // Controls and ready during FETCH must be ignored.
        jump_reg = 1'b1; reg_target = 32'hDEAD_BEEF; instr_ready = 1'b1; imem_ack = 1'b0;
        repeat (v.ack_wait) begin
            @(negedge clk);
            chk("wait_addr", imem_addr, e);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
        end
        clear_ctrl();
        instr_ready = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = v.word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_instr", instr, v.word);
        chk("hold_imm16", {16'd0, imm16}, {16'd0, v.word[15:0]});
        chk("hold_pc", pc, e);
        chk("hold_pc4", pc_plus4, e + 32'd4);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
        repeat (v.stall) begin
            imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; jump = 1'b1;
            @(negedge clk);
            chk("stall_instr", instr, v.word);
            chk("stall_pc", pc, e);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        imem_ack = 1'b0; imem_rdata = '0;
        branch_taken = v.br; jump = v.j; jump_reg = v.jr; imm_ext = v.imm; reg_target = v.rt;
        instr_ready = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
        if (m_pend_v) begin
            nx = m_pend;
            m_pend_v = 1'b0;
        end else if (v.jr || v.j || v.br) begin
            m_pend   = ref_target(e, v);
            m_pend_v = 1'b1;
            nx = e + 32'd4;
        end else begin
            nx = e + 32'd4;
        end
`else
        nx = v.exp_next;
`endif
        sb.push_back(nx);
        @(negedge clk);
        instr_ready = 1'b0;
        clear_ctrl();
        chk("misalign", {31'd0, misalign}, {31'd0, v.exp_mis});
        chk("post_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        n_pass = 0; n_total = 0; m_pend = '0; m_pend_v = 1'b0;
        //               word          br    j     jr    imm            rt             aw st exp_next       mis
        vecs[0]  = '{32'h2001_0005, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 0, 32'h0000_0004, 1'b0};
        vecs[1]  = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         2, 0, 32'h0000_0008, 1'b0};
        vecs[2]  = '{32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 0, 32'h0000_0100, 1'b0};
        vecs[3]  = '{32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         1, 0, 32'h0000_0100, 1'b0};
        vecs[4]  = '{32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_2003, 0, 0, 32'h0000_2000, 1'b1};
        vecs[5]  = '{32'h1000_0010, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         0, 0, 32'h0000_2044, 1'b0};
        vecs[6]  = '{32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0040_0010, 0, 0, 32'h0040_0010, 1'b0};
        vecs[7]  = '{32'h0800_0100, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 0, 32'h0000_0400, 1'b0};
        vecs[8]  = '{32'h0800_0001, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 32'h8000_0000, 0, 0, 32'h8000_0000, 1'b0};
        vecs[9]  = '{32'h0800_0010, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         0, 0, 32'h8000_0040, 1'b0};
        vecs[10] = '{32'h1000_0000, 1'b1, 1'b0, 1'b0, 32'h3FFF_FFF0, 32'h0,         0, 0, 32'h8000_0004, 1'b0};
        vecs[11] = '{32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0,         32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFC, 1'b1};
        vecs[12] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 5, 32'h0000_0000, 1'b0};
        vecs[13] = '{32'h1000_0001, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0,         0, 1, 32'h0000_0008, 1'b0};

        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        clear_ctrl();
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_pc4", pc_plus4, 32'h4);
        reset = 1'b0;
        sb.push_back(32'h0);

        for (int i = 0; i < 14; i++) do_instr(vecs[i]);

        // Redirect, then reset while the following fetch waits on ack: in-flight fetch and pending target drop.
        vx = '{32'h1000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'h0000_040C, 1'b0};
        do_instr(vx);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        sb.push_back(32'h0);
        m_pend_v = 1'b0;
        chk("rst6_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst6_instr", instr, 32'h0);
        chk("rst6_pc", pc, 32'h0);
        vx = '{32'h2002_0001, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0000_0004, 1'b0};
        do_instr(vx);
        vx = '{32'h2002_0002, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 0, 32'h0000_0008, 1'b0};
        do_instr(vx);
        chk("final_addr", imem_addr, sb.size() != 0 ? sb[0] : 32'hxxxx_xxxx);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
